// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with a run controller: matches a configurable
// PAT_W-bit pattern on a gated bit stream, counts hits and stops at a threshold.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_thr,
  input  logic             start,
  input  logic             stop,
  input  logic             din,
  input  logic             din_vld,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_MIN = FW'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;
  logic             ovl_reg;
  logic [CNT_W-1:0] thr_reg;
  logic [PAT_W-1:0] hist_reg;
  logic [FW-1:0]    fill_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             match_reg;

  logic [PAT_W-1:0] hist_next;
  logic [CNT_W-1:0] cnt_next;
  logic [FW-1:0]    fill_next;
  logic             hit;

  // The incoming bit completes the window, so the match test looks one bit ahead.
  always_comb begin
    hist_next = {hist_reg[PAT_W-2:0], din};
    hit       = (hist_next == pat_reg) && (fill_reg >= FILL_MIN);
    cnt_next  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
    fill_next = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + FW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      ovl_reg   <= 1'b1;
      thr_reg   <= '0;
      hist_reg  <= '0;
      fill_reg  <= '0;
      cnt_reg   <= '0;
      match_reg <= 1'b0;
    end else begin
      match_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_we) begin
            pat_reg <= cfg_pat;
            ovl_reg <= cfg_ovl;
            thr_reg <= cfg_thr;
          end
          if (start && !stop) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            hist_reg  <= '0;
            fill_reg  <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (din_vld) begin
            hist_reg <= hist_next;
            if (hit) begin
              match_reg <= 1'b1;
              cnt_reg   <= cnt_next;
              fill_reg  <= ovl_reg ? fill_next : '0;
              if ((thr_reg != '0) && (cnt_next == thr_reg))
                state_reg <= DONE;
            end else begin
              fill_reg <= fill_next;
            end
          end
        end
        DONE: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (start) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            hist_reg  <= '0;
            fill_reg  <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign match     = match_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of threshold and match counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_pat  input  PAT_W  pattern; bit PAT_W-1 is the first bit received.
REQ-007 SHALL have port cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port cfg_thr  input  CNT_W  match threshold; 0 = unlimited.
REQ-009 SHALL have port start  input  1  begin or restart a detection run.
REQ-010 SHALL have port stop  input  1  abort the run and return to idle.
REQ-011 SHALL have port din  input  1  serial data bit.
REQ-012 SHALL have port din_vld  input  1  din is sampled only when this is 1.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port done  output  1  high while in DONE.
REQ-015 SHALL have port match  output  1  one-cycle registered match pulse.
REQ-016 SHALL have port match_cnt  output  CNT_W  matches counted in the current or last run.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DONE; busy = (RUN), done = (DONE).
REQ-018 SHALL capture cfg_pat, cfg_ovl, cfg_thr into internal registers on cfg_we only in IDLE.
REQ-019 SHALL ignore cfg_we in RUN and DONE; active config SHALL stay unchanged.
REQ-020 SHALL, on start in IDLE or DONE, enter RUN next cycle and clear match_cnt, shift history and fill count.
REQ-021 SHALL ignore start while in RUN; restart requires stop or DONE first.
REQ-022 SHALL, on stop in RUN or DONE, enter IDLE next cycle and hold match_cnt.
REQ-023 SHALL give stop priority over start and over a same-cycle din_vld; that bit SHALL be discarded.
REQ-024 SHALL, in RUN with din_vld=1, shift din into a PAT_W history (newest in LSB) and increment fill count, saturating at PAT_W.
REQ-025 SHALL detect a match when {history[PAT_W-2:0], din} == pattern and fill count >= PAT_W-1.
REQ-026 SHALL assert match for exactly the cycle after the matching sample and increment match_cnt on the same edge.
REQ-027 SHALL, in overlapping mode, keep history and fill count after a match.
REQ-028 SHALL, in non-overlapping mode, clear fill count to 0 on a match; the matching bit SHALL NOT count toward the next match.
REQ-029 SHALL enter DONE on the same edge that match_cnt reaches a nonzero cfg_thr.
REQ-030 SHALL, with cfg_thr = 0, stay in RUN and saturate match_cnt at 2^CNT_W-1 while still pulsing match.
REQ-031 SHALL ignore din and din_vld in IDLE and DONE; match SHALL stay 0 there.
REQ-032 SHALL leave history untouched by cycles with din_vld=0; gaps SHALL NOT break a sequence.

Reset
REQ-033 SHALL, on rst=0, immediately enter IDLE and set busy=0, done=0, match=0, match_cnt=0, history=0, fill=0.
REQ-034 SHALL reset config registers to pattern 0, cfg_ovl=1, cfg_thr=0.
REQ-035 SHALL abort any run on rst mid-operation; the first cycle after release SHALL be IDLE.

Verification
REQ-036 SHALL cover: pat=1010, ovl=1, thr=0, stream 1,0,1,0,1,0,1 -> match pulses after bits 4 and 6, match_cnt=2, busy stays 1.
REQ-037 SHALL cover: pat=1010, ovl=0, same stream -> single match after bit 4, match_cnt=1.
REQ-038 SHALL cover: pat=1010, ovl=1, thr=2, stream 10101010 -> DONE entered with the second match after bit 6, bits 7-8 ignored, match_cnt=2, done=1.
REQ-039 SHALL cover: stream 1,0,1,0 with din_vld=0 for 3 cycles between every bit -> one match, same result as gap-free.
REQ-040 SHALL cover: cfg_we with pat=0110 during RUN -> ignored, detection continues on 1010; stop and start asserted together -> IDLE.
REQ-041 SHALL cover: rst pulled low after bit 3 of 1010 -> IDLE, all outputs 0; after release, start then bit 0 alone -> no match.
